data_ram_ahbl: RTL and testbench

AHB-Lite slave fronting the core's data RAM; the LSU's `dbus_*` master port lands directly on it. It accepts byte, halfword and word reads and writes. Reads return data one cycle after the address phase. Writes commit in the data phase using byte lanes decoded from `hsize` and `haddr[1:0]`. A store followed immediately by a load to the same word is forwarded in hardware, and misaligned, oversize or out-of-range accesses get the two-cycle AHB-Lite ERROR response.

---
 rtl/data_ram_ahbl_pkg.sv | 40 ++++
 rtl/data_ram_ahbl_1rw.sv | 24 ++
 rtl/data_ram_ahbl.sv | 142 ++++++++++++++
 tb/tb_data_ram_ahbl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_ahbl_pkg.sv
// Shared AHB-Lite encodings for the data RAM slave and the LSU master,
// plus the byte-lane decode used by both.
package data_ram_ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_OKAY = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } resp_state_e;

    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << lo;
            HSIZE_HALF: mask = 4'b0011 << {lo[1], 1'b0};
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Size/alignment faults only; the range check depends on the RAM size.
    function automatic logic align_error(input logic [2:0] size, input logic [1:0] lo);
        return (size > HSIZE_WORD) ||
               (size == HSIZE_HALF && lo[0]) ||
               (size == HSIZE_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/data_ram_ahbl_1rw.sv
// Synchronous 1R1W word RAM with byte write enables; registered read that
// returns the old word when a read and write hit the same address.
module data_ram_1rw #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/data_ram_ahbl.sv
// AHB-Lite slave in front of the core data RAM: decode, two-cycle error
// response, data-phase write commit and store-to-load forwarding.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_OKAY | normal operation, hready=1 hresp=0
//   ST_ERR1 | first error cycle, hready=0 hresp=1, bus inputs ignored
//   ST_ERR2 | second error cycle, hready=1 hresp=1, next address sampled
module data_ram_ahbl
    import data_ram_ahbl_pkg::*;
#(
    parameter int RAM_BYTES = 16384,
    parameter int RAM_AW    = $clog2(RAM_BYTES / 4)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  dbus_htrans,
    input  logic        dbus_hwrite,
    input  logic [2:0]  dbus_hsize,
    input  logic [2:0]  dbus_hburst,
    input  logic [3:0]  dbus_hport,
    input  logic        dbus_hmastlock,
    input  logic [31:0] dbus_haddr,
    input  logic [31:0] dbus_hwdata,
    output logic        dbus_hready,
    output logic        dbus_hresp,
    output logic [31:0] dbus_hrdata
);

    localparam logic [31:0] RAM_LIMIT = 32'(RAM_BYTES);

    resp_state_e       state;
    logic              accept;
    logic              addr_err;
    logic              addr_ok;
    logic [RAM_AW-1:0] a_idx;
    logic [3:0]        a_mask;

    logic              dp_valid;
    logic              dp_write;
    logic [RAM_AW-1:0] dp_idx;
    logic [3:0]        dp_mask;
    logic              wr_commit;
    logic [3:0]        ram_we;
    logic [31:0]       ram_q;
    logic              rd_valid;
    logic [3:0]        fwd_mask;
    logic [31:0]       fwd_data;

    logic unused_ok;
    assign unused_ok = ^{dbus_hburst, dbus_hport, dbus_hmastlock};

    assign accept   = dbus_hready & dbus_htrans[1];
    assign addr_err = align_error(dbus_hsize, dbus_haddr[1:0]) | (dbus_haddr >= RAM_LIMIT);
    assign addr_ok  = accept & ~addr_err;
    assign a_idx    = dbus_haddr[RAM_AW+1:2];
    assign a_mask   = byte_mask(dbus_hsize, dbus_haddr[1:0]);

    assign wr_commit = dp_valid & dp_write;
    // A write whose data phase coincides with reset is dropped.
    assign ram_we    = (wr_commit && !rst) ? dp_mask : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_OKAY;
            dbus_hready <= 1'b1;
            dbus_hresp  <= HRESP_OKAY;
        end else begin
            case (state)
                ST_OKAY, ST_ERR2: begin
                    if (accept && addr_err) begin
                        state       <= ST_ERR1;
                        dbus_hready <= 1'b0;
                        dbus_hresp  <= HRESP_ERROR;
                    end else begin
                        state       <= ST_OKAY;
                        dbus_hready <= 1'b1;
                        dbus_hresp  <= HRESP_OKAY;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    dbus_hready <= 1'b1;
                    dbus_hresp  <= HRESP_ERROR;
                end
                default: begin
                    state       <= ST_OKAY;
                    dbus_hready <= 1'b1;
                    dbus_hresp  <= HRESP_OKAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_mask  <= 4'b0000;
            rd_valid <= 1'b0;
            fwd_mask <= 4'b0000;
            fwd_data <= 32'h0;
        end else begin
            dp_valid <= addr_ok;
            if (addr_ok) begin
                dp_write <= dbus_hwrite;
                dp_idx   <= a_idx;
                dp_mask  <= a_mask;
            end
            rd_valid <= addr_ok & ~dbus_hwrite;
            // The RAM returns the pre-write word on a same-cycle collision,
            // so the lanes being stored are patched in on the next cycle.
            if (wr_commit && addr_ok && !dbus_hwrite && a_idx == dp_idx) begin
                fwd_mask <= dp_mask;
                fwd_data <= dbus_hwdata;
            end else begin
                fwd_mask <= 4'b0000;
            end
        end
    end

    data_ram_1rw #(.AW(RAM_AW)) u_ram (
        .clk   (clk),
        .re    (addr_ok & ~dbus_hwrite),
        .raddr (a_idx),
        .rdata (ram_q),
        .we    (ram_we),
        .waddr (dp_idx),
        .wdata (dbus_hwdata)
    );

    always_comb begin
        dbus_hrdata = 32'h0;
        if (rd_valid) begin
            for (int i = 0; i < 4; i++) begin
                dbus_hrdata[8*i +: 8] = fwd_mask[i] ? fwd_data[8*i +: 8] : ram_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_ram_ahbl.sv
// Directed bench for data_ram_ahbl: read/write, forwarding, error response
// and reset during a write data phase.
module tb_data_ram_ahbl;
    import data_ram_ahbl_pkg::*;

    localparam logic [1:0] IDL = HTRANS_IDLE;
    localparam logic [1:0] NSQ = HTRANS_NONSEQ;
    localparam logic [2:0] SB  = HSIZE_BYTE;
    localparam logic [2:0] SH  = HSIZE_HALF;
    localparam logic [2:0] SW  = HSIZE_WORD;

    logic        clk;
    logic        rst;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    int err_cnt = 0;
    int chk_cnt = 0;

    data_ram_ahbl #(.RAM_BYTES(16384)) dut (
        .clk            (clk),
        .rst            (rst),
        .dbus_htrans    (htrans),
        .dbus_hwrite    (hwrite),
        .dbus_hsize     (hsize),
        .dbus_hburst    (3'b000),
        .dbus_hport     (4'b0011),
        .dbus_hmastlock (1'b0),
        .dbus_haddr     (haddr),
        .dbus_hwdata    (hwdata),
        .dbus_hready    (hready),
        .dbus_hresp     (hresp),
        .dbus_hrdata    (hrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive just after the rising edge, return at the falling edge.
    task automatic cycle(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd, input logic r = 1'b0);
        @(posedge clk);
        #1;
        htrans = tr; hwrite = wr; hsize = sz; haddr = ad; hwdata = wd; rst = r;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; htrans = IDL; hwrite = 1'b0; hsize = SW; haddr = 32'h0; hwdata = 32'h0;
        repeat (3) @(posedge clk);
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hready !== 1'b1) begin err_cnt++; $display("FAIL reset_hready got=%b exp=1", hready); end
        chk_cnt++; if (hresp !== 1'b0) begin err_cnt++; $display("FAIL reset_hresp got=%b exp=0", hresp); end
        chk_cnt++; if (hrdata !== 32'h0) begin err_cnt++; $display("FAIL reset_hrdata got=%h exp=00000000", hrdata); end
    endtask

    task automatic test_word_rw();
        cycle(NSQ, 1, SW, 32'h0000_0000, 32'h0);
        cycle(NSQ, 1, SW, 32'h0000_0100, 32'hCAFE_F00D);
        cycle(IDL, 0, SW, 32'h0, 32'hDEAD_BEEF);
        chk_cnt++; if (hready !== 1'b1 || hresp !== 1'b0) begin err_cnt++; $display("FAIL sw_dphase hready=%b hresp=%b exp=1/0", hready, hresp); end
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        cycle(NSQ, 0, SW, 32'h0000_0100, 32'h0);
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hrdata !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL word_rd got=%h exp=deadbeef", hrdata); end
        chk_cnt++; if (hready !== 1'b1 || hresp !== 1'b0) begin err_cnt++; $display("FAIL word_rd_resp hready=%b hresp=%b exp=1/0", hready, hresp); end
        // last word in range, read back-to-back through full-word forwarding
        cycle(NSQ, 1, SW, 32'h0000_3FFC, 32'h0);
        cycle(NSQ, 0, SW, 32'h0000_3FFC, 32'h0BAD_F00D);
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hrdata !== 32'h0BAD_F00D || hresp !== 1'b0) begin err_cnt++; $display("FAIL last_word got=%h hresp=%b exp=0badf00d/0", hrdata, hresp); end
    endtask

    task automatic test_fwd_byte();
        cycle(NSQ, 1, SW, 32'h0000_0200, 32'h0);
        cycle(NSQ, 1, SB, 32'h0000_0201, 32'h1122_3344);
        chk_cnt++; if (hready !== 1'b1) begin err_cnt++; $display("FAIL b2b_wr_hready got=%b exp=1", hready); end
        cycle(NSQ, 0, SW, 32'h0000_0200, 32'hAAAA_AAAA);
        chk_cnt++; if (hready !== 1'b1) begin err_cnt++; $display("FAIL b2b_rd_hready got=%b exp=1", hready); end
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hrdata !== 32'h1122_AA44) begin err_cnt++; $display("FAIL fwd_byte got=%h exp=1122aa44", hrdata); end
        cycle(NSQ, 1, SB, 32'h0000_0203, 32'h0);
        cycle(IDL, 0, SW, 32'h0, 32'h7777_7777);
        cycle(NSQ, 0, SW, 32'h0000_0200, 32'h0);
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hrdata !== 32'h7722_AA44) begin err_cnt++; $display("FAIL byte_lane3 got=%h exp=7722aa44", hrdata); end
    endtask

    task automatic test_fwd_half();
        cycle(NSQ, 1, SW, 32'h0000_0300, 32'h0);
        cycle(NSQ, 1, SH, 32'h0000_0302, 32'h0000_0000);
        cycle(NSQ, 0, SH, 32'h0000_0300, 32'hBEEF_BEEF);
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hrdata !== 32'hBEEF_0000) begin err_cnt++; $display("FAIL fwd_half got=%h exp=beef0000", hrdata); end
        // write to another word followed by a read: RAM data, nothing patched in
        cycle(NSQ, 1, SW, 32'h0000_0304, 32'h0);
        cycle(NSQ, 0, SW, 32'h0000_0300, 32'h5555_5555);
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hrdata !== 32'hBEEF_0000) begin err_cnt++; $display("FAIL no_fwd_other_word got=%h exp=beef0000", hrdata); end
        // read followed by write to the same word returns the old value
        cycle(NSQ, 0, SW, 32'h0000_0300, 32'h0);
        cycle(NSQ, 1, SW, 32'h0000_0300, 32'h0);
        chk_cnt++; if (hrdata !== 32'hBEEF_0000) begin err_cnt++; $display("FAIL rd_then_wr got=%h exp=beef0000", hrdata); end
        cycle(IDL, 0, SW, 32'h0, 32'h9999_9999);
        cycle(NSQ, 0, SW, 32'h0000_0300, 32'h0);
        cycle(NSQ, 0, SW, 32'h0000_0304, 32'h0);
        chk_cnt++; if (hrdata !== 32'h9999_9999) begin err_cnt++; $display("FAIL rd_after_wr got=%h exp=99999999", hrdata); end
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hrdata !== 32'h5555_5555) begin err_cnt++; $display("FAIL rd_other_word got=%h exp=55555555", hrdata); end
    endtask

    task automatic test_error_misaligned();
        cycle(NSQ, 0, SW, 32'h0000_0102, 32'h0);
        chk_cnt++; if (hready !== 1'b1 || hresp !== 1'b0) begin err_cnt++; $display("FAIL mis_aphase hready=%b hresp=%b exp=1/0", hready, hresp); end
        // a write presented during ERR1 must be ignored
        cycle(NSQ, 1, SW, 32'h0000_0000, 32'h0);
        chk_cnt++; if (hready !== 1'b0 || hresp !== 1'b1) begin err_cnt++; $display("FAIL mis_err1 hready=%b hresp=%b exp=0/1", hready, hresp); end
        cycle(IDL, 0, SW, 32'h0, 32'h0000_FFFF);
        chk_cnt++; if (hready !== 1'b1 || hresp !== 1'b1) begin err_cnt++; $display("FAIL mis_err2 hready=%b hresp=%b exp=1/1", hready, hresp); end
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hready !== 1'b1 || hresp !== 1'b0) begin err_cnt++; $display("FAIL mis_okay hready=%b hresp=%b exp=1/0", hready, hresp); end
        cycle(NSQ, 1, SW, 32'h0000_0102, 32'h0);
        cycle(IDL, 0, SW, 32'h0, 32'hFFFF_FFFF);
        chk_cnt++; if (hready !== 1'b0 || hresp !== 1'b1) begin err_cnt++; $display("FAIL mis_sw_err1 hready=%b hresp=%b exp=0/1", hready, hresp); end
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        cycle(NSQ, 0, SW, 32'h0000_0100, 32'h0);
        cycle(NSQ, 0, SW, 32'h0000_0000, 32'h0);
        chk_cnt++; if (hrdata !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL mis_sw_intact got=%h exp=deadbeef", hrdata); end
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hrdata !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL err1_ignored got=%h exp=cafef00d", hrdata); end
    endtask

    task automatic test_error_chain();
        cycle(NSQ, 1, SW, 32'h0000_4000, 32'h0);
        cycle(IDL, 0, SW, 32'h0, 32'h1212_1212);
        chk_cnt++; if (hready !== 1'b0 || hresp !== 1'b1) begin err_cnt++; $display("FAIL oor_err1 hready=%b hresp=%b exp=0/1", hready, hresp); end
        cycle(NSQ, 0, 3'b011, 32'h0000_0000, 32'h0);
        chk_cnt++; if (hready !== 1'b1 || hresp !== 1'b1) begin err_cnt++; $display("FAIL oor_err2 hready=%b hresp=%b exp=1/1", hready, hresp); end
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hready !== 1'b0 || hresp !== 1'b1) begin err_cnt++; $display("FAIL chain_err1 hready=%b hresp=%b exp=0/1", hready, hresp); end
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hready !== 1'b1 || hresp !== 1'b1) begin err_cnt++; $display("FAIL chain_err2 hready=%b hresp=%b exp=1/1", hready, hresp); end
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hready !== 1'b1 || hresp !== 1'b0) begin err_cnt++; $display("FAIL chain_okay hready=%b hresp=%b exp=1/0", hready, hresp); end
        cycle(NSQ, 1, SH, 32'h0000_0201, 32'h0);
        cycle(IDL, 0, SW, 32'h0, 32'hFFFF_FFFF);
        chk_cnt++; if (hresp !== 1'b1) begin err_cnt++; $display("FAIL half_mis_hresp got=%b exp=1", hresp); end
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        cycle(NSQ, 0, SW, 32'h0000_0000, 32'h0);
        cycle(NSQ, 0, SW, 32'h0000_0200, 32'h0);
        chk_cnt++; if (hrdata !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL oor_intact got=%h exp=cafef00d", hrdata); end
        cycle(NSQ, 0, SW, 32'h0000_3FFC, 32'h0);
        chk_cnt++; if (hrdata !== 32'h7722_AA44) begin err_cnt++; $display("FAIL half_mis_intact got=%h exp=7722aa44", hrdata); end
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hrdata !== 32'h0BAD_F00D) begin err_cnt++; $display("FAIL last_word_intact got=%h exp=0badf00d", hrdata); end
    endtask

    task automatic test_reset_mid_write();
        cycle(NSQ, 1, SW, 32'h0000_0040, 32'h0);
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        cycle(NSQ, 1, SW, 32'h0000_0040, 32'h0);
        // reset lands on the write data phase, with a same-word read queued
        cycle(NSQ, 0, SW, 32'h0000_0040, 32'h1234_5678, 1'b1);
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hready !== 1'b1 || hresp !== 1'b0) begin err_cnt++; $display("FAIL post_rst_resp hready=%b hresp=%b exp=1/0", hready, hresp); end
        chk_cnt++; if (hrdata !== 32'h0) begin err_cnt++; $display("FAIL post_rst_hrdata got=%h exp=00000000", hrdata); end
        cycle(NSQ, 0, SW, 32'h0000_0040, 32'h0);
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hrdata !== 32'h0) begin err_cnt++; $display("FAIL rst_wr_suppressed got=%h exp=00000000", hrdata); end
        // reset while the error response is in progress
        cycle(NSQ, 0, SW, 32'h0000_0002, 32'h0);
        cycle(IDL, 0, SW, 32'h0, 32'h0, 1'b1);
        cycle(IDL, 0, SW, 32'h0, 32'h0);
        chk_cnt++; if (hready !== 1'b1 || hresp !== 1'b0) begin err_cnt++; $display("FAIL rst_in_err hready=%b hresp=%b exp=1/0", hready, hresp); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_rw();
        test_fwd_byte();
        test_fwd_half();
        test_error_misaligned();
        test_error_chain();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
